// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op codes, FIFO entry type and the wide-result helper
package alu_pkg;
    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_OR  = 4'h3;
    localparam logic [3:0] ALU_XOR = 4'h4;
    localparam logic [3:0] ALU_SHL = 4'h5;
    localparam logic [3:0] ALU_SHR = 4'h6;
    localparam logic [3:0] ALU_SRA = 4'h7;
    localparam logic [3:0] ALU_MUL = 4'h8;
    localparam logic [3:0] ALU_DIV = 4'h9;
    localparam logic [3:0] ALU_NEG = 4'hA;
    localparam logic [3:0] ALU_NOT = 4'hB;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        zero;
        logic        neg;
    } result_entry_t;

    // Only mul/div produce a 64-bit hi/lo pair; every other code, defined or not, is single-word.
    function automatic logic is_wide(input logic [3:0] select);
        return select == ALU_MUL || select == ALU_DIV;
    endfunction
endpackage

// File: rtl/alu_result_stage_if.sv
// alu_result_stage_if: result push side and Z-register pop side of the ALU result stage
interface alu_result_stage_if #(parameter int CNT_W = 16);
    logic [31:0]      z;
    logic [31:0]      hi;
    logic [31:0]      lo;
    logic [3:0]       select;
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic             out_valid;
    logic [31:0]      out_lo;
    logic [31:0]      out_hi;
    logic             out_pop;
    logic             out_zero;
    logic             out_neg;
    logic [CNT_W-1:0] acc_count;

    modport master (
        output z, hi, lo, select, in_valid, flush, out_pop,
        input  in_ready, out_valid, out_lo, out_hi, out_zero, out_neg, acc_count
    );
    modport slave (
        input  z, hi, lo, select, in_valid, flush, out_pop,
        output in_ready, out_valid, out_lo, out_hi, out_zero, out_neg, acc_count
    );
endinterface

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: generic DEPTH x W register FIFO with push/pop/flush and occupancy count
module alu_result_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [AW:0]  count,
    output logic         empty
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          full, do_push, do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
            count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage needs no reset: nothing reads a slot until a push has written it.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: queues ALU results and presents the oldest as the ZHi/ZLo pair.
// Define ALU_RESULT_FLAGS_EN to store per-entry zero/neg flags for out_zero/out_neg.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input logic               clk,
    input logic               rst_n,
    alu_result_stage_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
`ifdef ALU_RESULT_FLAGS_EN
    localparam int W = $bits(result_entry_t);
`else
    localparam int W = 64;
`endif

    logic             wide, push, empty;
    logic [31:0]      cap_hi, cap_lo;
    logic [W-1:0]     din, dout;
    logic [AW:0]      count;
    logic [CNT_W-1:0] acc;

    assign wide          = is_wide(bus.select);
    assign cap_hi        = wide ? bus.hi : 32'h0;
    assign cap_lo        = wide ? bus.lo : bus.z;
    assign bus.in_ready  = count < (AW+1)'(DEPTH);
    assign bus.out_valid = ~empty;
    assign bus.acc_count = acc;
    assign push          = bus.in_valid & bus.in_ready;

`ifdef ALU_RESULT_FLAGS_EN
    result_entry_t cap, head;
    // Non-wide captures carry hi=0, so the 64-bit zero test reduces to z==0.
    assign cap  = '{hi: cap_hi, lo: cap_lo, zero: {cap_hi, cap_lo} == 64'h0,
                    neg: wide ? bus.hi[31] : bus.z[31]};
    assign din  = cap;
    assign head = dout;
    assign {bus.out_hi, bus.out_lo} = empty ? 64'h0 : {head.hi, head.lo};
    assign bus.out_zero = ~empty & head.zero;
    assign bus.out_neg  = ~empty & head.neg;
`else
    assign din = {cap_hi, cap_lo};
    assign {bus.out_hi, bus.out_lo} = empty ? 64'h0 : dout;
    assign bus.out_zero = 1'b0;
    assign bus.out_neg  = 1'b0;
`endif

    alu_result_fifo #(.DEPTH(DEPTH), .W(W)) fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (bus.out_pop),
        .flush (bus.flush),
        .din   (din),
        .dout  (dout),
        .count (count),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc <= '0;
        else if (push & ~bus.flush) acc <= acc + CNT_W'(1);
    end
endmodule
